// File: rtl/order_25d_ctrl.sv
// Sequencing controller for the 25-input sorter: serial window fill, fixed-latency wait,
// result capture and valid/ready drain (full window or median only).
module order_25d_ctrl #(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned SORT_LAT = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  med_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DSIZE-1:0]      in_data,
  output logic [25*DSIZE-1:0]   sort_id,
  input  logic [25*DSIZE-1:0]   sort_od,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DSIZE-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           win_cnt
);

  localparam int unsigned WaitW = $clog2(SORT_LAT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StFill, StWait, StDrain} state_e;

  state_e               state_q, state_d;
  logic [4:0]           fill_idx_q, fill_idx_d;
  logic [4:0]           out_idx_q, out_idx_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 med_q, med_d;
  logic [15:0]          win_cnt_q, win_cnt_d;
  logic [25*DSIZE-1:0]  bank_q, bank_d;
  logic [25*DSIZE-1:0]  cap_q, cap_d;
  logic                 last_beat;
  logic [4:0]           out_sel;

  assign last_beat = med_q || (out_idx_q == 5'd24);
  assign out_sel   = med_q ? 5'd12 : out_idx_q;

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    out_idx_d  = out_idx_q;
    wait_cnt_d = wait_cnt_q;
    med_d      = med_q;
    win_cnt_d  = win_cnt_q;
    bank_d     = bank_q;
    cap_d      = cap_q;
    // Flush beats any concurrent handshake; the bank keeps its stale contents.
    if (flush) begin
      state_d    = StFill;
      fill_idx_d = '0;
      out_idx_d  = '0;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StFill;
        StFill: begin
          if (in_valid) begin
            bank_d[fill_idx_q*DSIZE +: DSIZE] = in_data;
            if (fill_idx_q == 5'd0) med_d = med_mode;
            if (fill_idx_q == 5'd24) begin
              state_d    = StWait;
              wait_cnt_d = '0;
            end else begin
              fill_idx_d = fill_idx_q + 5'd1;
            end
          end
        end
        StWait: begin
          if (wait_cnt_q == WaitW'(SORT_LAT)) begin
            cap_d     = sort_od;
            out_idx_d = '0;
            state_d   = StDrain;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (last_beat) begin
              win_cnt_d  = win_cnt_q + 16'd1;
              fill_idx_d = '0;
              state_d    = StFill;
            end else begin
              out_idx_d = out_idx_q + 5'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fill_idx_q <= '0;
      out_idx_q  <= '0;
      wait_cnt_q <= '0;
      med_q      <= 1'b0;
      win_cnt_q  <= '0;
      bank_q     <= '0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      out_idx_q  <= out_idx_d;
      wait_cnt_q <= wait_cnt_d;
      med_q      <= med_d;
      win_cnt_q  <= win_cnt_d;
      bank_q     <= bank_d;
      cap_q      <= cap_d;
    end
  end

  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StDrain);
  assign busy      = (state_q == StWait) || (state_q == StDrain);
  assign out_last  = out_valid && last_beat;
  assign out_data  = cap_q[out_sel*DSIZE +: DSIZE];
  assign sort_id   = bank_q;
  assign win_cnt   = win_cnt_q;

endmodule

// File: doc/order_25d_ctrl.md
# order_25d_ctrl

Sequencing controller for the 25-input, two-stage sorting pipeline. It collects a 5x5 window as a serial stream of 25 samples and presents it to the sorter as a flattened parallel bus. Because the sorter has no valid signal, the controller times the sorter's fixed latency with a counter, captures the sorted result, and streams it out under valid/ready backpressure. In median mode it emits only the centre element. It sits between the pixel-window front end and downstream filter logic, and it owns the sorter instance's input and output buses.

## Interface
Parameters:
- DSIZE, 8, sample width in bits.
- SORT_LAT, 2, sorter pipeline depth in clock edges from a stable input to a valid output.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous abort; discards the current window and any pending output.
- med_mode  in  1  1 = emit od12 only; 0 = emit all 25 sorted elements. Sampled on the edge that accepts input beat 0 of each window.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts a sample.
- in_data  in  DSIZE  input sample; window beat k maps to id(k).
- sort_id  out  25*DSIZE  window bank to the sorter; bits [k*DSIZE +: DSIZE] = id(k).
- sort_od  in  25*DSIZE  sorter outputs; bits [k*DSIZE +: DSIZE] = od(k).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DSIZE  output beat data.
- out_last  out  1  final beat of the window.
- busy  out  1  high in any state other than IDLE or FILL.
- win_cnt  out  16  number of windows fully drained; wraps at 0xFFFF -> 0.

## Operation
- States: IDLE -> FILL -> WAIT -> DRAIN -> FILL.
- IDLE: entered on reset. Leaves to FILL unconditionally on the first edge after rst_n deasserts.
- FILL:
  - in_ready = 1.
  - Each in_valid && in_ready handshake writes in_data into bank slot fill_idx, then increments fill_idx (0..24).
  - On the beat-24 handshake, go to WAIT and clear the wait counter.
- WAIT:
  - in_ready = 0; the bank is held stable.
  - The wait counter counts SORT_LAT+1 cycles.
  - On the final edge, latch all of sort_od into the capture register, clear out_idx, and go to DRAIN.
- DRAIN:
  - out_valid = 1.
  - med_mode latched 0: out_data = capture[out_idx]. out_idx advances 0..24 on each handshake. out_last = (out_idx == 24).
  - med_mode latched 1: out_data = capture[12] on a single beat, with out_last = 1.
  - On the last-beat handshake: win_cnt++, fill_idx = 0, go to FILL.
- Output values: out_data is don't-care when out_valid = 0.
- flush: in any state, the next edge sets the state to FILL and clears fill_idx, out_idx and the wait counter. win_cnt is not incremented. Bank contents are not cleared.
- Arithmetic: all counters wrap only as stated above. fill_idx and out_idx are 5 bits; values above 24 are never reached.

## Timing
- Reset values: state IDLE; in_ready 0; out_valid 0; out_last 0; busy 0; win_cnt 0; sort_id all-zero; out_data 0; all indices and counters 0.
- Latency: out_valid rises SORT_LAT+1 edges after the edge that accepts input beat 24 (3 edges at the defaults).
- Throughput:
  - Full window: 25 + (SORT_LAT+1) + 25 cycles minimum.
  - Median mode: 25 + (SORT_LAT+1) + 1 cycles minimum.
- Input handshake:
  - in_ready does not depend combinationally on in_valid.
  - A beat held with in_valid = 1 while in_ready = 0 is not consumed.
- Output handshake:
  - Under out_ready = 0, out_data and out_last hold stable.
  - out_valid never drops without a handshake, except on flush or reset.
- Simultaneous events:
  - flush together with an input or output handshake: flush wins and the beat is discarded.
  - Beat-24 accept together with flush: the window is dropped and the controller stays in FILL with fill_idx = 0.
- Reset mid-operation: asynchronous return to the reset values; no partial output follows.

## Test plan
- Fill with 24,23,...,0, med_mode = 0, out_ready = 1, sorter sort_od = ascending 0..24: out_valid rises 3 edges after beat 24 is accepted. Outputs are 0..24 on 25 consecutive cycles, out_last is high only on value 24, and win_cnt = 1.
- Same window with med_mode = 1: exactly one beat with out_data = 12 and out_last = 1. The controller returns to FILL and in_ready = 1 on the next cycle.
- Backpressure: toggle out_ready as 1,0,0,1,... during DRAIN. Each value appears exactly once, in order, and stays stable while stalled. Input in_valid = 1 during WAIT/DRAIN is never accepted.
- Flush on beat 10 of FILL, then a full new window: the first 10 beats are discarded, the second window drains correctly, and win_cnt increments by 1 only.
- Assert rst_n = 0 during DRAIN at out_idx = 7: all outputs reach their reset values immediately. One cycle after release the controller is in FILL with in_ready = 1, and win_cnt = 0.
- Preload win_cnt to 0xFFFF via 65535 median windows (or force it): the next drained window wraps win_cnt to 0.
